// File: rtl/parallel_to_serial.sv
// parallel_to_serial: WIDTH-bit word to LSB-first bit stream.
// load/ready handshake, hold stall, gapless back-to-back words.
module parallel_to_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             hold,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             first,
  output logic             last,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CMAX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_n;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic             done_q;
  logic             done_n;

  assign out_valid = (state == SHIFT);
  assign first     = out_valid & (cnt == '0);
  assign last      = out_valid & (cnt == CMAX);
  assign ready     = (state == IDLE) | (last & ~hold);
  assign out       = out_valid & sreg[0];
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      sreg   <= sreg_n;
      cnt    <= cnt_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          sreg_n  = in;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (!hold) begin
          if (cnt != CMAX) begin
            sreg_n = {1'b0, sreg[WIDTH-1:1]};
            cnt_n  = cnt + 1'b1;
          end else if (load) begin
            // Final bit: reload directly so the next word has no gap
            sreg_n = in;
            cnt_n  = '0;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb_parallel_to_serial: queue scoreboard with a word-level model,
// directed scenarios followed by randomized load/hold/reset traffic.
module tb_parallel_to_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] din;
  logic         hold;
  logic         ready;
  logic         out;
  logic         out_valid;
  logic         first;
  logic         last;
  logic         done;

  always #5 clk = ~clk;

  parallel_to_serial #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .in       (din),
    .hold     (hold),
    .ready    (ready),
    .out      (out),
    .out_valid(out_valid),
    .first    (first),
    .last     (last),
    .done     (done)
  );

  typedef struct packed {
    logic       b;
    logic [7:0] i;
  } ebit_t;

  ebit_t        q[$];
  logic [W-1:0] wq[$];
  logic [W-1:0] rxw;
  int           rem;
  logic         exp_done;
  logic         mon_en;
  int           checks;
  int           errors;

  task automatic chk(string n, logic [31:0] g, logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", n, g, e, $time);
    end
  endtask

  // Word-level model: rem = bits of the current word still to be emitted
  task automatic model();
    bit acc;
    acc = 1'b0;
    exp_done = 1'b0;
    if (rst) begin
      rem = 0;
      q.delete();
      wq.delete();
    end else if (rem == 0) begin
      acc = load;
    end else if (!hold) begin
      if (rem > 1) rem--;
      else if (load) acc = 1'b1;
      else begin
        rem = 0;
        exp_done = 1'b1;
      end
    end
    if (acc) begin
      rem = W;
      for (int i = 0; i < W; i++)
        q.push_back('{b: din[i], i: 8'(i)});
      wq.push_back(din);
    end
  endtask

  task automatic step(logic r, logic l, logic [W-1:0] d, logic h);
    rst  = r;
    load = l;
    din  = d;
    hold = h;
    @(posedge clk);
    model();
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic er;
      logic [W-1:0] ew;
      er = (q.size() == 0);
      if (q.size() != 0) er = (q[0].i == 8'(W - 1)) && !hold;
      chk("ready", ready, er);
      chk("done", done, exp_done);
      chk("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("out", out, q[0].b);
        chk("first", first, q[0].i == 0);
        chk("last", last, q[0].i == 8'(W - 1));
        rxw[q[0].i[2:0]] = out;
        if (!hold) begin
          if (q[0].i == 8'(W - 1)) begin
            ew = wq.pop_front();
            chk("rx_word", rxw, ew);
          end
          void'(q.pop_front());
        end
      end else begin
        chk("out_idle", out, 0);
        chk("first_idle", first, 0);
        chk("last_idle", last, 0);
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rem      = 0;
    exp_done = 1'b0;
    mon_en   = 1'b0;
    rxw      = '0;
    step(1, 0, 0, 0);
    mon_en = 1'b1;
    step(1, 1, 8'hFF, 1);
    // basic word
    step(0, 1, 8'hB5, 0);
    repeat (10) step(0, 0, 0, 0);
    // back-to-back, second load during the last cycle
    step(0, 1, 8'hB5, 0);
    repeat (7) step(0, 0, 0, 0);
    step(0, 1, 8'h13, 0);
    repeat (10) step(0, 0, 0, 0);
    // hold on bit 2 for 3 cycles with a load pulse inside
    step(0, 1, 8'hF0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 1, 8'h5A, 1);
    step(0, 0, 0, 1);
    repeat (8) step(0, 0, 0, 0);
    // load while busy
    step(0, 1, 8'h00, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 8'hFF, 0);
    repeat (6) step(0, 0, 0, 0);
    // reset mid-word on bit 4
    step(0, 1, 8'hAA, 0);
    repeat (4) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 8'h01, 0);
    repeat (10) step(0, 0, 0, 0);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(99) == 0,
           $urandom_range(9) < 4,
           W'($urandom),
           $urandom_range(9) < 2);
    end
    repeat (12) step(0, 0, 0, 0);
    chk("drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
